// File: rtl/popcount_pkg.sv
// Shared types and helpers for the packet popcount accumulator.
package popcount_pkg;

    // Widest data word popcount_w supports; narrower words are zero-extended.
    localparam int POP_MAX_W = 64;
    localparam int POP_CNT_W = $clog2(POP_MAX_W) + 1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } accum_state_t;

    function automatic logic [POP_CNT_W-1:0] popcount_w(input logic [POP_MAX_W-1:0] data);
        logic [POP_CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            acc = acc + POP_CNT_W'(data[i]);
        end
        return acc;
    endfunction

    function automatic int cnt_width(input int width, input int words);
        return $clog2(width * words + 1);
    endfunction

endpackage

// File: rtl/popcount_stage.sv
// First pipeline stage: registers the popcount of one data word with its
// valid/last qualifiers. Advances only while en_i is high.
module popcount_stage import popcount_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic             last_i,
    output logic [CW-1:0]    cnt_o,
    output logic             valid_o,
    output logic             last_o
);

    logic [POP_MAX_W-1:0] data_ext;
    logic [CW-1:0]        cnt_reg;
    logic                 valid_reg;
    logic                 last_reg;

    genvar gi;
    for (gi = 0; gi < POP_MAX_W; gi++) begin : g_ext
        if (gi < WIDTH) begin : g_bit
            assign data_ext[gi] = data_i[gi];
        end else begin : g_pad
            assign data_ext[gi] = 1'b0;
        end
    end

    // Payload only loads on a valid word so idle data never reaches stage 2.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else if (en_i) begin
            valid_reg <= valid_i;
            if (valid_i) begin
                last_reg <= last_i;
                cnt_reg  <= CW'(popcount_w(data_ext));
            end
        end
    end

    assign cnt_o   = cnt_reg;
    assign valid_o = valid_reg;
    assign last_o  = last_reg;

endmodule

// File: rtl/popcount_pkt_accum.sv
// Accumulates per-word popcounts over a packet and presents a saturating total.
// Optional word-count output enabled by defining POPCOUNT_PKT_WORDS_EN.
module popcount_pkt_accum import popcount_pkg::*; #(
    parameter int WIDTH     = 16,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = cnt_width(WIDTH, MAX_WORDS)
`ifdef POPCOUNT_PKT_WORDS_EN
    ,
    parameter int WORDS_W   = $clog2(MAX_WORDS + 1)
`endif
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               data_valid_i,
    input  logic               data_last_i,
    output logic               data_ready_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               cnt_sat_o,
    output logic               cnt_valid_o,
`ifdef POPCOUNT_PKT_WORDS_EN
    output logic [WORDS_W-1:0] cnt_words_o,
`endif
    input  logic               cnt_ready_i
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = ((CNT_W > CW) ? CNT_W : CW) + 1;

    logic [CW-1:0]       s1_cnt;
    logic                s1_valid;
    logic                s1_last;

    accum_state_t        state_reg, state_next;
    logic [CNT_W-1:0]    sum_reg, cnt_reg, sum_next, sum_add;
    logic [AW-CNT_W-1:0] sum_carry;
    logic                sat_reg, cnt_sat_reg;
    logic                s2_accepts, beat, beat_last, out_xfer;
    logic                sum_ovf, sat_step;

    popcount_stage #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_stage (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .en_i    (data_ready_o),
        .data_i  (data_i),
        .valid_i (data_valid_i),
        .last_i  (data_last_i),
        .cnt_o   (s1_cnt),
        .valid_o (s1_valid),
        .last_o  (s1_last)
    );

    // Only a last beat needs the result register, so only it can stall.
    assign out_xfer     = (state_reg == HOLD) && cnt_ready_i;
    assign s2_accepts   = !(s1_last && (state_reg == HOLD) && !cnt_ready_i);
    assign data_ready_o = !s1_valid || s2_accepts;
    assign beat         = s1_valid && s2_accepts;
    assign beat_last    = beat && s1_last;

    assign {sum_carry, sum_add} = AW'(sum_reg) + AW'(s1_cnt);
    assign sum_ovf  = |sum_carry;
    assign sum_next = sum_ovf ? {CNT_W{1'b1}} : sum_add;

`ifdef POPCOUNT_PKT_WORDS_EN
    logic [WORDS_W-1:0] words_reg, words_out_reg, words_next;
    logic               words_ovf;

    assign words_ovf  = &words_reg;
    assign words_next = words_ovf ? words_reg : words_reg + WORDS_W'(1);
    assign sat_step   = sum_ovf || words_ovf;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            words_reg     <= '0;
            words_out_reg <= '0;
        end else if (beat_last) begin
            words_out_reg <= words_next;
            words_reg     <= '0;
        end else if (beat) begin
            words_reg <= words_next;
        end
    end

    assign cnt_words_o = words_out_reg;
`else
    assign sat_step = sum_ovf;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (beat_last) state_next = HOLD;
            HOLD:    if (out_xfer && !beat_last) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // A last beat in HOLD only gets here alongside an output transfer.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg   <= ACCUM;
            sum_reg     <= '0;
            sat_reg     <= 1'b0;
            cnt_reg     <= '0;
            cnt_sat_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (beat_last) begin
                cnt_reg     <= sum_next;
                cnt_sat_reg <= sat_reg || sat_step;
                sum_reg     <= '0;
                sat_reg     <= 1'b0;
            end else if (beat) begin
                sum_reg <= sum_next;
                sat_reg <= sat_reg || sat_step;
            end
        end
    end

    assign cnt_o       = cnt_reg;
    assign cnt_sat_o   = cnt_sat_reg;
    assign cnt_valid_o = (state_reg == HOLD);

endmodule
